mac_st_stream: RTL and testbench

//  Parametrised, streaming Sum-Together MAC for BW-bit max precision with 3-level scalability
//  (BW x BW, 2 x BW/2, 4 x BW/4 sub-products summed). Replaces the fixed 8-bit MAC top.

---
 rtl/mac_st_pkg.sv | 30 +++
 rtl/mac_st_mult.sv | 51 +++++
 rtl/mac_st_stream.sv | 164 ++++++++++++++++
 tb/tb_mac_st_stream.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mac_st_pkg.sv
// Shared types and helpers for the streaming Sum-Together MAC (mac_st_stream).
package mac_st_pkg;

    typedef enum logic [1:0] {
        CFG_FULL  = 2'b00,
        CFG_HALF  = 2'b01,
        CFG_QUART = 2'b11
    } cfg_e;

    typedef struct packed {
        cfg_e mode;
        logic w_signed;
    } beat_cfg_t;

    function automatic int zw(input int bw, input int headroom);
        return 2 * bw + headroom;
    endfunction

    // The unused encoding 2'b10 behaves as full precision.
    function automatic cfg_e decode_cfg(input logic [1:0] aw);
        cfg_e mode;
        case (aw)
            2'b01:   mode = CFG_HALF;
            2'b11:   mode = CFG_QUART;
            default: mode = CFG_FULL;
        endcase
        return mode;
    endfunction

endpackage

// File: rtl/mac_st_mult.sv
// Combinational Sum-Together multiplier: sums 1, 2 or 4 same-index slice products,
// each extended to ZW bits (activations unsigned, weights signed on request).
module mac_st_mult
    import mac_st_pkg::*;
#(
    parameter int BW = 8,
    parameter int ZW = 20
) (
    input  logic [BW-1:0] a,
    input  logic [BW-1:0] w,
    input  beat_cfg_t     cfg,
    output logic [ZW-1:0] p
);

    // Keeps the low `width` bits of v and sign- or zero-extends them to ZW.
    function automatic logic [ZW-1:0] ext(input logic [BW-1:0] v, input int unsigned width,
                                          input logic sgn);
        logic [ZW-1:0] mask;
        logic [ZW-1:0] r;
        logic          msb;
        mask = (ZW'(1) << width) - ZW'(1);
        r    = ZW'(v) & mask;
        msb  = |((v >> (width - 1)) & BW'(1));
        if (sgn && msb) r = r | ~mask;
        return r;
    endfunction

    // Products are formed modulo 2^ZW, which is exact for ZW-bit two's complement results.
    function automatic logic [ZW-1:0] st_sum(input logic [BW-1:0] av, input logic [BW-1:0] wv,
                                             input int unsigned n, input logic sgn);
        logic [ZW-1:0] acc;
        int unsigned   width;
        width = BW / n;
        acc   = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (i < n)
                acc = acc + ext(av >> (i * width), width, 1'b0) * ext(wv >> (i * width), width, sgn);
        end
        return acc;
    endfunction

    // NOTE: every output of a combinational block is assigned on every path, so no latch forms.
    always_comb begin
        case (cfg.mode)
            CFG_HALF:  p = st_sum(a, w, 2, cfg.w_signed);
            CFG_QUART: p = st_sum(a, w, 4, cfg.w_signed);
            default:   p = st_sum(a, w, 1, cfg.w_signed);
        endcase
    end

endmodule

// File: rtl/mac_st_stream.sv
// Streaming Sum-Together MAC: 3-stage pipeline with valid/ready, programmable group length
// and per-beat config. Optional saturating accumulation under `MAC_ST_SAT_EN.
module mac_st_stream
    import mac_st_pkg::*;
#(
    parameter int BW       = 8,
    parameter int HEADROOM = 4,
    parameter int CNT_W    = 8,
    localparam int ZW      = zw(BW, HEADROOM)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BW-1:0]    a,
    input  logic [BW-1:0]    w,
    input  logic             w_signed,
    input  logic [1:0]       config_aw,
    input  logic [CNT_W-1:0] acc_len,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ZW-1:0]    z,
    output logic             busy,
    output logic             ovf
);

    logic             stall;
    logic             accept;
    logic [CNT_W-1:0] in_cnt;
    logic [CNT_W-1:0] grp_len;
    logic [CNT_W-1:0] beat_len;
    beat_cfg_t        grp_cfg;
    beat_cfg_t        beat_cfg;
    logic             grp_start;
    logic             beat_last;

    logic [BW-1:0]    a1;
    logic [BW-1:0]    w1;
    beat_cfg_t        cfg1;
    logic             last1;
    logic             v1;
    logic [ZW-1:0]    p1;

    logic [ZW-1:0]    p2;
    logic             last2;
    logic             v2;

    logic [ZW-1:0]    acc;
    logic [ZW-1:0]    acc_sum;

    assign stall     = out_valid && !out_ready;
    assign in_ready  = !stall;
    assign accept    = in_valid && in_ready;
    assign grp_start = (in_cnt == '0);
    assign busy      = (in_cnt != '0) || v1 || v2;

    // The first beat of a group takes its config from the ports; later beats reuse the latched copy.
    always_comb begin
        beat_cfg = grp_cfg;
        beat_len = grp_len;
        if (grp_start) begin
            beat_cfg.mode     = decode_cfg(config_aw);
            beat_cfg.w_signed = w_signed;
            beat_len          = (acc_len == '0) ? CNT_W'(1) : acc_len;
        end
    end

    assign beat_last = (in_cnt == beat_len - CNT_W'(1));

    mac_st_mult #(.BW(BW), .ZW(ZW)) u_mult (
        .a   (a1),
        .w   (w1),
        .cfg (cfg1),
        .p   (p1)
    );

`ifdef MAC_ST_SAT_EN
    logic          ws2;
    logic          clamp;
    logic          ovf_q;
    logic [ZW:0]   sum_ext;

    always_comb begin
        sum_ext = {ws2 & acc[ZW-1], acc} + {ws2 & p2[ZW-1], p2};
        acc_sum = sum_ext[ZW-1:0];
        clamp   = 1'b0;
        if (ws2) begin
            if (sum_ext[ZW] != sum_ext[ZW-1]) begin
                clamp   = 1'b1;
                acc_sum = sum_ext[ZW] ? {1'b1, {(ZW-1){1'b0}}} : {1'b0, {(ZW-1){1'b1}}};
            end
        end else if (sum_ext[ZW]) begin
            clamp   = 1'b1;
            acc_sum = '1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ws2   <= 1'b0;
            ovf_q <= 1'b0;
        end else if (!stall) begin
            if (v1) ws2 <= cfg1.w_signed;
            if (v2 && clamp) ovf_q <= 1'b1;
        end
    end

    assign ovf = ovf_q;
`else
    assign acc_sum = acc + p2;
    assign ovf     = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_cnt    <= '0;
            grp_len   <= '0;
            grp_cfg   <= '{mode: CFG_FULL, w_signed: 1'b0};
            a1        <= '0;
            w1        <= '0;
            cfg1      <= '{mode: CFG_FULL, w_signed: 1'b0};
            last1     <= 1'b0;
            v1        <= 1'b0;
            p2        <= '0;
            last2     <= 1'b0;
            v2        <= 1'b0;
            acc       <= '0;
            z         <= '0;
            out_valid <= 1'b0;
        end else if (!stall) begin
            v1 <= accept;
            if (accept) begin
                a1     <= a;
                w1     <= w;
                cfg1   <= beat_cfg;
                last1  <= beat_last;
                in_cnt <= beat_last ? '0 : in_cnt + CNT_W'(1);
                if (grp_start) begin
                    grp_cfg <= beat_cfg;
                    grp_len <= beat_len;
                end
            end

            v2 <= v1;
            if (v1) begin
                p2    <= p1;
                last2 <= last1;
            end

            // Not stalled means any held result is being popped; a finishing group replaces it.
            out_valid <= v2 && last2;
            if (v2) begin
                if (last2) begin
                    z   <= acc_sum;
                    acc <= '0;
                end else begin
                    acc <= acc_sum;
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_st_stream.sv
// Directed self-checking bench for mac_st_stream (BW=8, HEADROOM=4, ZW=20); honours MAC_ST_SAT_EN.
module tb_mac_st_stream;

    localparam int BW    = 8;
    localparam int CNT_W = 8;
    localparam int ZW    = 20;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [BW-1:0]    a;
    logic [BW-1:0]    w;
    logic             w_signed;
    logic [1:0]       config_aw;
    logic [CNT_W-1:0] acc_len;
    logic             out_valid;
    logic             out_ready;
    logic [ZW-1:0]    z;
    logic             busy;
    logic             ovf;

    int n_vec = 0;
    int n_err = 0;

    logic [ZW-1:0] exp_z;
    logic          exp_ovf;

    mac_st_stream #(.BW(BW), .HEADROOM(4), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .w         (w),
        .w_signed  (w_signed),
        .config_aw (config_aw),
        .acc_len   (acc_len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .busy      (busy),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one beat, waits (bounded) for in_ready, lets it be accepted, then drops in_valid.
    task automatic send(input logic [7:0] av, input logic [7:0] wv, input logic ws,
                        input logic [1:0] cfg, input logic [7:0] len);
        a         = av;
        w         = wv;
        w_signed  = ws;
        config_aw = cfg;
        acc_len   = len;
        in_valid  = 1'b1;
        for (int i = 0; i < 50 && !in_ready; i++) step();
        if (!in_ready) check("send_ready_timeout", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag, input logic [ZW-1:0] expz);
        for (int i = 0; i < 60 && !out_valid; i++) step();
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check(tag, {12'd0, z}, {12'd0, expz});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        w         = '0;
        w_signed  = 1'b0;
        config_aw = 2'b00;
        acc_len   = 8'd1;
        out_ready = 1'b1;

        #12;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_z",         {12'd0, z},         32'd0);
        check("rst_busy",      {31'd0, busy},      32'd0);
        check("rst_ovf",       {31'd0, ovf},       32'd0);
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        step();
        rst_n = 1'b1;
        step();

        // Reset in the middle of a 4-beat group drops it.
        for (int i = 0; i < 3; i++) send(8'd1, 8'd1, 1'b0, 2'b00, 8'd4);
        step();
        check("mid_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_z",         {12'd0, z},         32'd0);
        check("mid_rst_busy",      {31'd0, busy},      32'd0);
        a        = 8'hFF;
        w        = 8'hFF;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("rst_beat_dropped", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        step();

        // 4-beat group: later beats ask for half mode / len 1, which must be ignored.
        // Full 8x8: 0x12*0x13 = 18*19 = 342, four beats = 1368.
        send(8'h12, 8'h13, 1'b0, 2'b00, 8'd4);
        for (int i = 0; i < 3; i++) send(8'h12, 8'h13, 1'b0, 2'b01, 8'd1);
        wait_result("grp4_z", 20'd1368);

        // 8x8 signed, len 2: 255 * -128 twice = -65280.
        send(8'hFF, 8'h80, 1'b1, 2'b00, 8'd2);
        send(8'hFF, 8'h80, 1'b1, 2'b00, 8'd2);
        wait_result("s8x8_z", 20'hF0100);
        step();
        check("s8x8_one_clk", {31'd0, out_valid}, 32'd0);

        // 2 x 4-bit unsigned, len 1, back to back: 2*15*15=450, 1*3+2*4=11, 15*15+0=225.
        send(8'hFF, 8'hFF, 1'b0, 2'b01, 8'd1);
        send(8'h21, 8'h43, 1'b0, 2'b01, 8'd1);
        send(8'h0F, 8'h0F, 1'b0, 2'b01, 8'd1);
        wait_result("h4x4_0", 20'd450);
        step();
        check("h4x4_1_valid", {31'd0, out_valid}, 32'd1);
        check("h4x4_1",       {12'd0, z},         32'd11);
        step();
        check("h4x4_2_valid", {31'd0, out_valid}, 32'd1);
        check("h4x4_2",       {12'd0, z},         32'd225);
        step();
        check("h4x4_done",    {31'd0, out_valid}, 32'd0);

        // 4 x 2-bit signed: slices a=3, w=-2, four products = -24.
        send(8'hFF, 8'hAA, 1'b0 | 1'b1, 2'b11, 8'd1);
        wait_result("q2x2_z", 20'hFFFE8);

        // config 10 behaves as full, acc_len 0 as 1: 0x13*0x15 = 19*21 = 399.
        send(8'h13, 8'h15, 1'b0, 2'b10, 8'd0);
        wait_result("cfg10_len0_z", 20'd399);
        step();

        // Backpressure: result held, input blocked, nothing lost.
        out_ready = 1'b0;
        send(8'd10, 8'd10, 1'b0, 2'b00, 8'd1);
        send(8'd7,  8'd3,  1'b0, 2'b00, 8'd1);
        step();
        check("bp_valid",    {31'd0, out_valid}, 32'd1);
        check("bp_z",        {12'd0, z},         32'd100);
        check("bp_in_ready", {31'd0, in_ready},  32'd0);
        a         = 8'd2;
        w         = 8'd2;
        w_signed  = 1'b0;
        config_aw = 2'b00;
        acc_len   = 8'd1;
        in_valid  = 1'b1;
        repeat (5) step();
        check("bp_hold_z",     {12'd0, z},        32'd100);
        check("bp_hold_ready", {31'd0, in_ready}, 32'd0);
        check("bp_hold_busy",  {31'd0, busy},     32'd1);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("bp_next_valid", {31'd0, out_valid}, 32'd1);
        check("bp_next_z",     {12'd0, z},         32'd21);
        step();
        check("bp_gap", {31'd0, out_valid}, 32'd0);
        wait_result("bp_third_z", 20'd4);
        check("pre_ovf", {31'd0, ovf}, 32'd0);

        // 17 x 255*255 = 1105425: wraps to 56849, or saturates with the flag set.
`ifdef MAC_ST_SAT_EN
        exp_z   = 20'hFFFFF;
        exp_ovf = 1'b1;
`else
        exp_z   = 20'd56849;
        exp_ovf = 1'b0;
`endif
        for (int i = 0; i < 17; i++) send(8'hFF, 8'hFF, 1'b0, 2'b00, 8'd17);
        wait_result("ovf_z", exp_z);
        check("ovf_flag", {31'd0, ovf}, {31'd0, exp_ovf});
        step();
        check("end_busy",  {31'd0, busy},      32'd0);
        check("end_valid", {31'd0, out_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
